rule_sequencer: RTL and testbench
=================================

// Module: rule_sequencer
// PURPOSE
//  Sequences the fuzzy rule base for the frequency-regulation FLC. Takes one snapshot of
//  active input fuzzy sets plus membership degrees from the fuzzifier, presents each active
//  set ID to the rule base one at a time in ascending order, and waits out its latency.
//  Streams the resulting (output set ID, firing strength) pairs to the defuzzifier over a
//  valid/ready handshake.
// PARAMETERS
//  NUM_SETS    11  number of input fuzzy sets; set IDs are 1..NUM_SETS
//  ID_W        8   width of fuzzy set IDs (rule base interface)
//  MU_W        8   width of one membership degree / firing strength
//  RB_LATENCY  1   clock edges from rb_input_id sampled to rb_output_id valid (>=1)
// PORTS
//  clk            in   1              system clock, rising edge
//  rst_n          in   1              asynchronous active-low reset
//  start          in   1              pulse: latch active_mask/mu_in and run one pass
//  active_mask    in   NUM_SETS       bit i set => input set ID i+1 is active
//  mu_in          in   NUM_SETS*MU_W  degree of set ID i+1 at bits [i*MU_W +: MU_W]
//  rb_input_id    out  ID_W           set ID presented to the rule base
//  rb_output_id   in   ID_W           output set ID returned by the rule base
//  out_valid      out  1              out_set_id/out_strength/out_last valid
//  out_ready      in   1              defuzzifier accepts the beat
//  out_set_id     out  ID_W           consequent (output) fuzzy set ID
//  out_strength   out  MU_W           firing strength = latched degree of the antecedent set
//  out_last       out  1              final beat of this pass
//  busy           out  1              pass in progress (state != IDLE)
//  done           out  1              one-cycle pulse: pass complete
//  rule_count     out  $clog2(NUM_SETS+1)  beats emitted in last pass; valid from done
//  map_error      out  1              sticky: rule base returned ID 0 for a nonzero input
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State -> IDLE; every output -> 0; latched mask/mu cleared.
//   - Reset mid-pass abandons the pass; no done pulse.
//  States: IDLE, WAIT, EMIT, DONE.
//  IDLE
//   - start=1 at an edge: latch mask/mu, clear rule_count and map_error.
//   - Mask zero -> DONE.
//   - Otherwise rb_input_id <= lowest active ID, wait counter <= RB_LATENCY -> WAIT.
//  WAIT
//   - Counter decrements each edge. At the edge where it reads 0, capture
//     out_set_id <= rb_output_id and out_strength <= mu of the current ID.
//   - out_last <= (no higher active bit); out_valid <= 1 -> EMIT.
//  EMIT
//   - out_* held stable while out_ready=0.
//   - On out_valid&out_ready, rule_count increments.
//   - If last: out_valid <= 0, rb_input_id <= 0 -> DONE.
//   - Otherwise rb_input_id <= next higher active ID, counter reload, out_valid <= 0 -> WAIT.
//  DONE
//   - done=1 for exactly this cycle -> IDLE; busy=0 from IDLE on.
//  Timing
//   - First out_valid rises RB_LATENCY+1 edges after the start edge.
//   - out_valid is low for RB_LATENCY+1 cycles between beats when out_ready is held high.
//   - rb_input_id is stable from issue through capture and is 0 in IDLE/DONE.
//  Boundaries
//   - start while busy is ignored; no relatch.
//   - Captured ID 0 for a nonzero input ID: map_error <= 1; the beat is still emitted with ID 0.
//   - rule_count holds until the next accepted start.
//   - Bits of active_mask above NUM_SETS do not exist; no wrap-around.
// TESTING
//  1. mask=bit0 (ID1), mu1=8'h80, ready=1
//     -> one beat {11,8'h80,last=1} at start+2 edges; done next; rule_count=1.
//  2. mask=ID2,ID3, mu2=8'h40, mu3=8'hC0
//     -> beats {10,8'h40,0} then {9,8'hC0,1}; rule_count=2.
//  3. As 2, with out_ready low for 5 cycles on the first beat
//     -> out_* stable; second beat only after the handshake.
//  4. mask=0 -> no out_valid; done pulse 1 cycle after start; rule_count=0; busy low after.
//  5. All 11 bits set -> beats IDs 11..1 in order; last on ID1; rule_count=11.
//     start re-pulsed mid-pass is ignored.
//  6. rst_n low mid-pass -> all outputs 0 immediately; no done.
//     Then stub rb_output_id=0 on the next pass -> map_error=1, beat ID 0.

Source files
------------

// File: rtl/rule_sequencer.sv
// rule_sequencer: walks the latched active-set mask in ascending ID order through the rule base
// and streams (consequent ID, firing strength) beats over a valid/ready handshake.
module rule_sequencer #(
    parameter int NUM_SETS   = 11,
    parameter int ID_W       = 8,
    parameter int MU_W       = 8,
    parameter int RB_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_SETS-1:0]           active_mask,
    input  logic [NUM_SETS*MU_W-1:0]      mu_in,
    output logic [ID_W-1:0]               rb_input_id,
    input  logic [ID_W-1:0]               rb_output_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_set_id,
    output logic [MU_W-1:0]               out_strength,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_SETS+1)-1:0] rule_count,
    output logic                          map_error
);
    localparam int RC_W = $clog2(NUM_SETS+1);
    localparam int LW   = $clog2(RB_LATENCY+1);

    typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [NUM_SETS-1:0]      mask_q, mask_d, hi_mask;
    logic [NUM_SETS*MU_W-1:0] mu_q, mu_d;
    logic [ID_W-1:0]          rb_id_q, rb_id_d, out_id_q, out_id_d;
    logic [MU_W-1:0]          str_q, str_d, sel_mu;
    logic [LW-1:0]            cnt_q, cnt_d;
    logic [RC_W-1:0]          rc_q, rc_d;
    logic                     valid_q, valid_d, last_q, last_d, err_q, err_d;

    function automatic logic [ID_W-1:0] lowest(input logic [NUM_SETS-1:0] m);
        lowest = '0;
        for (int i = NUM_SETS-1; i >= 0; i--)
            if (m[i]) lowest = ID_W'(i+1);
    endfunction

    // Active sets above the one in flight, and the latched degree of the one in flight.
    always_comb begin
        hi_mask = '0;
        sel_mu  = '0;
        for (int i = 0; i < NUM_SETS; i++) begin
            hi_mask[i] = mask_q[i] && (ID_W'(i+1) > rb_id_q);
            if (rb_id_q == ID_W'(i+1)) sel_mu = mu_q[i*MU_W +: MU_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        mu_d     = mu_q;
        rb_id_d  = rb_id_q;
        out_id_d = out_id_q;
        str_d    = str_q;
        cnt_d    = cnt_q;
        rc_d     = rc_q;
        valid_d  = valid_q;
        last_d   = last_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (start) begin
                mask_d = active_mask;
                mu_d   = mu_in;
                rc_d   = '0;
                err_d  = 1'b0;
                if (active_mask == '0) begin
                    state_d = DONE;
                end else begin
                    rb_id_d = lowest(active_mask);
                    cnt_d   = LW'(RB_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: if (cnt_q == '0) begin
                out_id_d = rb_output_id;
                str_d    = sel_mu;
                last_d   = hi_mask == '0;
                valid_d  = 1'b1;
                err_d    = err_q || rb_output_id == '0;
                state_d  = EMIT;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            EMIT: if (out_ready) begin
                rc_d    = rc_q + 1'b1;
                valid_d = 1'b0;
                rb_id_d = last_q ? '0 : lowest(hi_mask);
                cnt_d   = LW'(RB_LATENCY);
                state_d = last_q ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            mu_q     <= '0;
            rb_id_q  <= '0;
            out_id_q <= '0;
            str_q    <= '0;
            cnt_q    <= '0;
            rc_q     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            mu_q     <= mu_d;
            rb_id_q  <= rb_id_d;
            out_id_q <= out_id_d;
            str_q    <= str_d;
            cnt_q    <= cnt_d;
            rc_q     <= rc_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign rb_input_id  = rb_id_q;
    assign out_valid    = valid_q;
    assign out_set_id   = out_id_q;
    assign out_strength = str_q;
    assign out_last     = last_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign rule_count   = rc_q;
    assign map_error    = err_q;
endmodule

// File: tb/tb_rule_sequencer.sv
// tb_rule_sequencer: directed passes with a queue scoreboard; the monitor pops on every handshake.
module tb_rule_sequencer;
    logic        clk, rst_n, start, out_ready, stub;
    logic [10:0] active_mask;
    logic [87:0] mu_in;
    logic [7:0]  rb_input_id, rb_output_id, out_set_id, out_strength;
    logic        out_valid, out_last, busy, done, map_error;
    logic [3:0]  rule_count;

    typedef struct packed {logic [7:0] id; logic [7:0] mu; logic last;} beat_t;
    beat_t exp_q[$];
    int n_chk = 0, n_pass = 0, done_cnt = 0;

    rule_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .active_mask(active_mask), .mu_in(mu_in),
        .rb_input_id(rb_input_id), .rb_output_id(rb_output_id), .out_valid(out_valid),
        .out_ready(out_ready), .out_set_id(out_set_id), .out_strength(out_strength),
        .out_last(out_last), .busy(busy), .done(done), .rule_count(rule_count),
        .map_error(map_error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Rule base stub: one-edge latency, ID k maps to 12-k (or 0 when stubbed broken).
    always @(posedge clk)
        rb_output_id <= (stub || rb_input_id == 0) ? 8'd0 : 8'd12 - rb_input_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {out_set_id, out_strength}, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_id", out_set_id, e.id);
                check("beat_strength", out_strength, e.mu);
                check("beat_last", out_last, e.last);
            end
        end
    end

    task automatic do_start(input logic [10:0] m, input logic [87:0] mu);
        @(posedge clk); #1;
        active_mask = m; mu_in = mu; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_rb_id", rb_input_id, 0);
    endtask

    initial begin
        logic [87:0] mu_all;
        logic [7:0] id0, s0;
        logic l0;
        bit seen;
        int d0;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [87:0] mu_all;
        logic [7:0] id0, s0;
        logic l0;
        bit seen;
        int d0;
        rst_n = 0; start = 0; out_ready = 1; stub = 0; active_mask = 0; mu_in = 0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rb_id", rb_input_id, 0);
        check("rst_count", rule_count, 0);
        rst_n = 1;

        // 1: single set, latency check
        exp_q.push_back('{8'd11, 8'h80, 1'b1});
        do_start(11'h001, 88'h80);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_rb_id", rb_input_id, 1);
        check("t1_valid_e0", out_valid, 0);
        @(negedge clk);
        check("t1_valid_e1", out_valid, 0);
        @(negedge clk);
        check("t1_valid_e2", out_valid, 1);
        wait_done(20);
        check("t1_count", rule_count, 1);
        check("t1_map_error", map_error, 0);

        // 2: two sets, ascending order
        exp_q.push_back('{8'd10, 8'h40, 1'b0});
        exp_q.push_back('{8'd9, 8'hC0, 1'b1});
        do_start(11'b110, 88'hC04000);
        wait_done(40);
        check("t2_count", rule_count, 2);

        // 3: backpressure on the first beat
        out_ready = 0;
        exp_q.push_back('{8'd10, 8'h40, 1'b0});
        exp_q.push_back('{8'd9, 8'hC0, 1'b1});
        do_start(11'b110, 88'hC04000);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("t3_valid_seen", seen, 1);
        id0 = out_set_id; s0 = out_strength; l0 = out_last;
        check("t3_first_id", id0, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_out", {out_set_id, out_strength, 7'd0, out_last}, {id0, s0, 7'd0, l0});
            check("t3_stall_rb_id", rb_input_id, 2);
        end
        @(posedge clk); #1;
        out_ready = 1;
        wait_done(40);
        check("t3_count", rule_count, 2);

        // 4: empty mask
        do_start(11'h0, 88'h0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_valid", out_valid, 0);
        @(negedge clk);
        check("t4_done_low", done, 0);
        check("t4_busy", busy, 0);
        check("t4_count", rule_count, 0);

        // 5: all sets, with an ignored mid-pass start
        mu_all = 0;
        for (int i = 0; i < 11; i++) begin
            mu_all[i*8 +: 8] = 8'(i*16 + 3);
            exp_q.push_back('{8'(11 - i), 8'(i*16 + 3), i == 10});
        end
        do_start(11'h7FF, mu_all);
        repeat (6) @(posedge clk);
        #1; start = 1; active_mask = 11'h001; mu_in = 0;
        @(posedge clk); #1; start = 0;
        wait_done(200);
        check("t5_count", rule_count, 11);
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: reset mid-pass, then a broken rule base
        for (int i = 0; i < 11; i++) exp_q.push_back('{8'(11 - i), 8'(i*16 + 3), i == 10});
        do_start(11'h7FF, mu_all);
        repeat (4) @(posedge clk);
        #1; rst_n = 0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_rb_id", rb_input_id, 0);
        check("t6_out", {out_set_id, out_strength, 7'd0, out_last}, 0);
        check("t6_count", rule_count, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1; rst_n = 1;
        repeat (5) @(negedge clk);
        check("t6_no_done", done_cnt, d0);
        stub = 1;
        exp_q.push_back('{8'd0, 8'h55, 1'b1});
        do_start(11'h001, 88'h55);
        wait_done(20);
        check("t6_map_error", map_error, 1);
        check("t6_count1", rule_count, 1);
        stub = 0;
        exp_q.push_back('{8'd7, 8'h77, 1'b1});
        do_start(11'h010, 88'h77_0000_0000);
        wait_done(20);
        check("t6_map_error_clear", map_error, 0);
        check("end_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
